fold_collect: RTL and testbench
===============================

# fold_collect

Fold sequencer and output assembler for the folded FC layer. Drives the `select` index of the 4-way weight mux one fold pass at a time, captures each pass's `DIM_OUT/FOLD` partial outputs from the MAC datapath into the matching slice of a full-width result register, and presents the assembled `DIM_OUT` vector downstream with a valid/ready handshake. Sits between the MAC array output and the next layer/readout.

## Interface
- `DIM_OUT`, 8: total output neurons (from DEF.sv).
- `FOLD`, 4: number of fold passes per sample; `DIM_OUT` is a multiple of `FOLD`.
- `LOG_FOLD`, 2: `clog2(FOLD)`; width of `select`.
- `OUTWD`, 16: width of one output word, two's complement.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a new input sample is presented to the datapath.
- `in_ready`  out  1  block can start a new sample.
- `select`  out  `LOG_FOLD`  fold index to the weight mux.
- `part_valid`  in  1  `part` holds the result for fold `select`.
- `part`  in  `DIM_OUT/FOLD` x `OUTWD`  partial output slice.
- `out_valid`  out  1  `out` holds a complete sample.
- `out_ready`  in  1  downstream accepts `out`.
- `out`  out  `DIM_OUT` x `OUTWD`  assembled output vector.
- `err`  out  1  sticky: `part_valid` seen outside RUN.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `in_ready`=1. `in_valid` → RUN, `select`=0.
- RUN: `in_ready`=0. On `part_valid`: write `part` into `out[select*DIM_OUT/FOLD +: DIM_OUT/FOLD]`; if `select`==`FOLD-1` → DONE and `select`→0, else `select`+1. No `part_valid` → hold.
- DONE: `out_valid`=1, `out` stable. `out_ready` → IDLE. `in_valid` ignored until IDLE (no overlap).
- `part_valid` in IDLE or DONE: data discarded, `out` unchanged, `err` set to 1; cleared only by `rst`.
- `select` wraps only via the DONE transition; never exceeds `FOLD-1`.
- Slots are not cleared on sample start; each sample overwrites every slot before DONE.

## Timing
- Reset values: `in_ready`=1 (IDLE), `select`=0, `out_valid`=0, `out`=all zero, `err`=0.
- `rst` mid-RUN or mid-DONE: immediate return to reset values; the partially assembled sample is lost.
- `select` updates the cycle after the `part_valid` that consumes it. The datapath sees each index for at least one cycle.
- `out_valid` rises the cycle after the final (`select`=`FOLD-1`) `part_valid`.
- `out_valid` falls and `in_ready` rises the cycle after `out_valid && out_ready`. The next sample can be accepted that cycle, so the minimum sample-to-sample spacing is `FOLD`+2 cycles.
- Same-cycle `out_ready` and `in_valid` in DONE: only `out_ready` acts.
- All outputs are registered except `in_ready`/`out_valid`, which are decoded from the state register only.

## Configuration
- `FOLD_RELU_EN` defined: each `part` word is clamped to 0 if its MSB is 1 before it is stored. `err` behaviour is unchanged.
- Undefined: words are stored unmodified.

## Test plan
- Reset, then `in_valid`, then 4 `part_valid` beats with slices {1,2},{3,4},{5,6},{7,8} → `select` steps 0,1,2,3; `out`={1..8} with slot 0 in the low index; `out_valid` 1 cycle after beat 4.
- Gaps of 3 idle cycles between `part_valid` beats → `select` holds; `out` is identical to the gap-free case.
- `out_ready` held low for 5 cycles in DONE, with `in_valid`=1 and a stray `part_valid` → `out` stable, `in_ready`=0, `err`=1, no new sample starts.
- `rst` asserted after 2 beats → next cycle `select`=0, `out`=0, `err`=0; a following full sample assembles correctly.
- Part word 16'hFFF0 → stored as 16'h0000 with `FOLD_RELU_EN` defined, 16'hFFF0 without it.
- Back-to-back samples with `out_ready`=1 constantly → sample 2 is accepted the cycle `in_ready` returns; spacing is 6 cycles.

Source files
------------

// File: rtl/fold_collect_if.sv
// Handshake and data bundle between the fold_collect sequencer and its
// neighbours: sample start from upstream, partial slices from the MAC array,
// and the assembled result to the next layer.
interface fold_collect_if #(
    parameter int DIM_OUT  = 8,
    parameter int FOLD     = 4,
    parameter int LOG_FOLD = 2,
    parameter int OUTWD    = 16
);
    localparam int SLICE = DIM_OUT / FOLD;

    logic                           in_valid;
    logic                           in_ready;
    logic [LOG_FOLD-1:0]            select;
    logic                           part_valid;
    logic [SLICE-1:0][OUTWD-1:0]    part;
    logic                           out_valid;
    logic                           out_ready;
    logic [DIM_OUT-1:0][OUTWD-1:0]  out;
    logic                           err;

    // Environment side: starts samples, supplies slices, consumes results.
    modport master (
        output in_valid, part_valid, part, out_ready,
        input  in_ready, select, out_valid, out, err
    );

    // Sequencer side.
    modport slave (
        input  in_valid, part_valid, part, out_ready,
        output in_ready, select, out_valid, out, err
    );
endinterface

// File: rtl/fold_collect.sv
// Fold sequencer and output assembler for the folded FC layer.
// Steps the weight-mux select through FOLD passes, stores each pass's
// partial slice into its slot of the result register, then holds the
// assembled vector until downstream accepts it.
// Optional feature: define FOLD_RELU_EN to clamp negative part words to
// zero before they are stored.
module fold_collect #(
    parameter int DIM_OUT  = 8,
    parameter int FOLD     = 4,
    parameter int LOG_FOLD = 2,
    parameter int OUTWD    = 16
) (
    input  logic          clk,
    input  logic          rst,
    fold_collect_if.slave bus
);
    localparam int                  SLICE    = DIM_OUT / FOLD;
    localparam logic [LOG_FOLD-1:0] LAST_SEL = LOG_FOLD'(FOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [LOG_FOLD-1:0]            select_q;
    // One entry per fold pass; entry 0 occupies the low words of out.
    logic [FOLD-1:0][SLICE*OUTWD-1:0] out_q;
    logic                           err_q;
    logic [SLICE-1:0][OUTWD-1:0]    part_w;
    logic                           take;
    logic                           last_beat;
    logic                           stray;

    assign take      = (state == RUN) && bus.part_valid;
    assign last_beat = take && (select_q == LAST_SEL);
    assign stray     = bus.part_valid && (state != RUN);

`ifdef FOLD_RELU_EN
    // Clamp each incoming word at zero when its sign bit is set.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        part_w = bus.part;
        for (int j = 0; j < SLICE; j++) begin
            if (bus.part[j][OUTWD-1]) begin
                part_w[j] = '0;
            end
        end
    end
`else
    assign part_w = bus.part;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; in_valid is ignored outside IDLE so samples never overlap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last_beat)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Fold index: advances per accepted slice, wraps to 0 only on the final slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_q <= '0;
        end else if (take) begin
            select_q <= last_beat ? '0 : select_q + 1'b1;
        end
    end

    // Result slots: overwritten slice by slice; not cleared between samples.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the result register is reset because downstream sees all
        // zeros out of reset; each slot is still fully rewritten per sample.
        if (rst) begin
            out_q <= '0;
        end else if (take) begin
            out_q[select_q] <= part_w;
        end
    end

    // Sticky error for slices arriving while no sample is being assembled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (stray) begin
            err_q <= 1'b1;
        end
    end

    assign bus.select = select_q;
    assign bus.out    = out_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_fold_collect.sv
// Self-checking bench for fold_collect: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// model that counts slices received and holds the result as a word array.
module tb_fold_collect;
    localparam int DIM_OUT  = 8;
    localparam int FOLD     = 4;
    localparam int LOG_FOLD = 2;
    localparam int OUTWD    = 16;
    localparam int SLICE    = DIM_OUT / FOLD;
    localparam int OUTBITS  = DIM_OUT * OUTWD;

    logic clk;
    logic rst;

    fold_collect_if #(
        .DIM_OUT(DIM_OUT), .FOLD(FOLD), .LOG_FOLD(LOG_FOLD), .OUTWD(OUTWD)
    ) bus ();

    fold_collect #(
        .DIM_OUT(DIM_OUT), .FOLD(FOLD), .LOG_FOLD(LOG_FOLD), .OUTWD(OUTWD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: words of the result, slices received this sample,
    // whether a sample is being collected or waiting to be taken.
    logic [OUTWD-1:0] m_out[DIM_OUT];
    int               m_taken;
    bit               m_collect;
    bit               m_full;
    bit               m_err;

    task automatic check(input string tag, input logic [OUTBITS-1:0] got,
                         input logic [OUTBITS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [OUTWD-1:0] relu(input logic [OUTWD-1:0] w);
`ifdef FOLD_RELU_EN
        return w[OUTWD-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [OUTBITS-1:0] model_vec();
        logic [OUTBITS-1:0] v;
        for (int i = 0; i < DIM_OUT; i++) v[i*OUTWD +: OUTWD] = m_out[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIM_OUT; i++) m_out[i] = '0;
        m_taken   = 0;
        m_collect = 0;
        m_full    = 0;
        m_err     = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_collect) begin
            if (bus.part_valid) begin
                for (int j = 0; j < SLICE; j++)
                    m_out[m_taken*SLICE + j] = relu(bus.part[j]);
                m_taken++;
                if (m_taken == FOLD) begin
                    m_taken   = 0;
                    m_collect = 0;
                    m_full    = 1;
                end
            end
        end else if (m_full) begin
            if (bus.part_valid) m_err = 1;
            if (bus.out_ready) m_full = 0;
        end else begin
            if (bus.part_valid) m_err = 1;
            if (bus.in_valid) m_collect = 1;
        end
    endtask

    task automatic compare_all();
        check("in_ready",  OUTBITS'(bus.in_ready),  OUTBITS'(!(m_collect || m_full)));
        check("out_valid", OUTBITS'(bus.out_valid), OUTBITS'(m_full));
        check("select",    OUTBITS'(bus.select),    OUTBITS'(m_taken));
        check("err",       OUTBITS'(bus.err),       OUTBITS'(m_err));
        check("out",       bus.out,                 model_vec());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Starts a sample, feeds FOLD slices from w with `gap` idle cycles between beats.
    task automatic run_sample(input logic [OUTWD-1:0] w[DIM_OUT], input int gap);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int f = 0; f < FOLD; f++) begin
            for (int j = 0; j < SLICE; j++) bus.part[j] = w[f*SLICE + j];
            bus.part_valid = 1'b1;
            step();
            bus.part_valid = 1'b0;
            bus.part = '0;
            if (f != FOLD - 1) repeat (gap) step();
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    localparam logic [OUTBITS-1:0] SEQ_VEC =
        128'h0008_0007_0006_0005_0004_0003_0002_0001;
`ifdef FOLD_RELU_EN
    localparam logic [OUTWD-1:0] NEG_STORED = 16'h0000;
`else
    localparam logic [OUTWD-1:0] NEG_STORED = 16'hFFF0;
`endif

    initial begin
        logic [OUTWD-1:0] w[DIM_OUT];
        int acc[$];

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.part_valid = 1'b0;
        bus.part       = '0;
        bus.out_ready  = 1'b0;
        model_reset();
        #2;
        check("reset_out",   bus.out, '0);
        check("reset_ready", OUTBITS'(bus.in_ready), OUTBITS'(1));
        step();
        rst = 1'b0;

        // Basic sample 1..8; slot 0 lands in the low words.
        for (int i = 0; i < DIM_OUT; i++) w[i] = OUTWD'(i + 1);
        run_sample(w, 0);
        check("seq_valid_after_last", OUTBITS'(bus.out_valid), OUTBITS'(1));
        check("seq_out", bus.out, SEQ_VEC);
        release_out();

        // Same data with 3-cycle gaps between beats.
        run_sample(w, 3);
        check("gap_out", bus.out, SEQ_VEC);

        // Hold in DONE: out_ready low, in_valid high, one stray slice.
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.part_valid = (k == 2);
            bus.part       = (k == 2) ? {16'hDEAD, 16'hBEEF} : '0;
            step();
        end
        bus.part_valid = 1'b0;
        bus.part       = '0;
        check("hold_out",     bus.out, SEQ_VEC);
        check("hold_ready",   OUTBITS'(bus.in_ready), OUTBITS'(0));
        check("hold_err",     OUTBITS'(bus.err), OUTBITS'(1));
        check("hold_valid",   OUTBITS'(bus.out_valid), OUTBITS'(1));
        bus.in_valid = 1'b0;
        release_out();

        // Reset after two beats of a sample, then a clean sample.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int f = 0; f < 2; f++) begin
            bus.part = {16'h1111, 16'h2222};
            bus.part_valid = 1'b1;
            step();
        end
        bus.part_valid = 1'b0;
        do_reset();
        check("rst_select", OUTBITS'(bus.select), OUTBITS'(0));
        check("rst_out",    bus.out, '0);
        check("rst_err",    OUTBITS'(bus.err), OUTBITS'(0));
        for (int i = 0; i < DIM_OUT; i++) w[i] = OUTWD'(16'h0100 * (i + 1) + i);
        run_sample(w, 1);
        check("post_rst_out", bus.out,
              128'h0807_0706_0605_0504_0403_0302_0201_0100);
        release_out();

        // Negative word handling.
        for (int i = 0; i < DIM_OUT; i++) w[i] = OUTWD'(i + 1);
        w[0] = 16'hFFF0;
        run_sample(w, 0);
        check("neg_word", OUTBITS'(bus.out[0]), OUTBITS'(NEG_STORED));
        release_out();

        // Back-to-back samples with everything asserted.
        do_reset();
        bus.in_valid   = 1'b1;
        bus.part_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int k = 0; k < 14; k++) begin
            bus.part = {16'($urandom), 16'($urandom)};
            if (bus.in_ready === 1'b1) acc.push_back(cyc);
            step();
        end
        check("b2b_count_ok", OUTBITS'(acc.size() >= 2), OUTBITS'(1));
        if (acc.size() >= 2)
            check("b2b_spacing", OUTBITS'(acc[1] - acc[0]), OUTBITS'(FOLD + 2));
        bus.in_valid   = 1'b0;
        bus.part_valid = 1'b0;
        bus.out_ready  = 1'b0;

        // Randomized traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            bus.in_valid   = ($urandom_range(0, 1) == 1);
            bus.part_valid = ($urandom_range(0, 9) < 6);
            bus.out_ready  = ($urandom_range(0, 9) < 4);
            for (int j = 0; j < SLICE; j++) bus.part[j] = OUTWD'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
